// File: rtl/result_reducer_bram_if.sv
// Bundles the controller handshake and the BRAM1 read port used by result_reducer_bram.
// The slave modport is the reducer; the master side is the controller/BRAM environment.
interface result_reducer_bram_if #(
  parameter int CNT_BIT   = 31,
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 12,
  parameter int RES_WIDTH = 16,
  parameter int ACC_WIDTH = 48
);
  logic                 i_run;
  logic [CNT_BIT-1:0]   i_num_cnt;
  logic                 o_idle;
  logic                 o_busy;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_done;
  logic [ACC_WIDTH-1:0] o_sum;
  logic [RES_WIDTH-1:0] o_max;
  logic [AWIDTH-1:0]    addr_b1;
  logic                 ce_b1;
  logic                 we_b1;
  logic [DWIDTH-1:0]    q_b1;
  logic [DWIDTH-1:0]    d_b1;

  modport slave (
    input  i_run, i_num_cnt, i_ready, q_b1,
    output o_idle, o_busy, o_valid, o_done, o_sum, o_max, addr_b1, ce_b1, we_b1, d_b1
  );

  modport master (
    output i_run, i_num_cnt, i_ready, q_b1,
    input  o_idle, o_busy, o_valid, o_done, o_sum, o_max, addr_b1, ce_b1, we_b1, d_b1
  );
endinterface

// File: rtl/result_reducer_bram.sv
// Reads N packed product pairs back from BRAM1, accumulating their sum and maximum,
// then presents {sum, max} to the controller through a valid/ready handshake.
module result_reducer_bram #(
  parameter int CNT_BIT   = 31,
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 12,
  parameter int RES_WIDTH = 16,
  parameter int ACC_WIDTH = 48
) (
  input logic                clk,
  input logic                reset_n,
  result_reducer_bram_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_BIT-1:0]   num_cnt_q, num_cnt_d;
  logic [CNT_BIT-1:0]   addr_cnt_q, addr_cnt_d;
  logic                 r_valid_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [RES_WIDTH-1:0] max_q, max_d;

  logic [RES_WIDTH-1:0] lo, hi, pair_max;
  logic                 ce;

  assign lo       = bus.q_b1[RES_WIDTH-1:0];
  assign hi       = bus.q_b1[DWIDTH-1:RES_WIDTH];
  assign pair_max = (lo > hi) ? lo : hi;
  assign ce       = (state_q == S_RUN);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    num_cnt_d  = num_cnt_q;
    addr_cnt_d = addr_cnt_q;
    acc_d      = acc_q;
    max_d      = max_q;

    // Read data lands one cycle after its address, including the word issued on the last S_RUN cycle.
    if (r_valid_q) begin
      acc_d = acc_q + ACC_WIDTH'(lo) + ACC_WIDTH'(hi);
      if (pair_max > max_q) max_d = pair_max;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_run) begin
          num_cnt_d  = bus.i_num_cnt;
          addr_cnt_d = '0;
          acc_d      = '0;
          max_d      = '0;
          state_d    = (bus.i_num_cnt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (addr_cnt_q == num_cnt_q - CNT_BIT'(1)) begin
          addr_cnt_d = '0;
          state_d    = S_DRAIN;
        end else begin
          addr_cnt_d = addr_cnt_q + CNT_BIT'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (bus.i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      num_cnt_q  <= '0;
      addr_cnt_q <= '0;
      r_valid_q  <= 1'b0;
      acc_q      <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_cnt_q  <= num_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      r_valid_q  <= ce;
      acc_q      <= acc_d;
      max_q      <= max_d;
    end
  end

  assign bus.o_idle  = (state_q == S_IDLE);
  assign bus.o_busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.o_valid = (state_q == S_DONE);
  assign bus.o_done  = bus.o_valid & bus.i_ready;
  assign bus.o_sum   = acc_q;
  assign bus.o_max   = max_q;
  assign bus.addr_b1 = addr_cnt_q[AWIDTH-1:0];
  assign bus.ce_b1   = ce;
  assign bus.we_b1   = 1'b0;
  assign bus.d_b1    = '0;

endmodule

// File: tb/tb_result_reducer_bram.sv
// Directed bench for result_reducer_bram with a synchronous-read BRAM1 model.
module tb_result_reducer_bram;
  localparam int CNT_BIT = 31, DWIDTH = 32, AWIDTH = 12, RES_WIDTH = 16, ACC_WIDTH = 48;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
  int ce_total = 0, run_base = 0, addr_err = 0;

  result_reducer_bram_if #(.CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
                           .RES_WIDTH(RES_WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  result_reducer_bram #(.CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
                        .RES_WIDTH(RES_WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // BRAM1: read data appears the cycle after ce_b1.
  always @(posedge clk) if (bus.ce_b1) bus.q_b1 <= mem[bus.addr_b1];

  // Read-address tracker: each run must issue addresses 0,1,2,... in consecutive reads.
  always @(negedge clk) begin
    if (bus.ce_b1) begin
      if (bus.addr_b1 !== AWIDTH'(ce_total - run_base) || bus.we_b1 !== 1'b0) addr_err++;
      ce_total++;
    end
  end

  task automatic run_job(input int n, input int repulse_k, output int lat);
    run_base      = ce_total;
    bus.i_run     = 1'b1;
    bus.i_num_cnt = CNT_BIT'(n);
    lat = -1;
    for (int k = 1; k <= n + 10; k++) begin
      @(negedge clk);
      if (k == repulse_k) begin
        bus.i_run     = 1'b1;
        bus.i_num_cnt = CNT_BIT'(7);
      end else begin
        bus.i_run = 1'b0;
      end
      if (bus.o_valid) begin
        lat = k;
        break;
      end
    end
    bus.i_run = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (bus.o_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", bus.o_idle); end
    total++; if ({bus.o_busy, bus.o_valid, bus.o_done, bus.ce_b1, bus.we_b1} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {bus.o_busy, bus.o_valid, bus.o_done, bus.ce_b1, bus.we_b1}); end
    total++; if (bus.o_sum !== '0 || bus.o_max !== '0 || bus.d_b1 !== '0) begin
      bad++; $display("FAIL reset_data sum=%0d max=%0d d=%0h want 0", bus.o_sum, bus.o_max, bus.d_b1); end
  endtask

  task automatic test_basic;
    int lat;
    mem[0] = 32'h0002_0001; mem[1] = 32'h0004_0003;
    bus.i_ready = 1'b1;
    run_job(2, 0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
    total++; if (bus.o_sum !== 48'd10) begin bad++; $display("FAIL basic_sum got=%0d want=10", bus.o_sum); end
    total++; if (bus.o_max !== 16'd4) begin bad++; $display("FAIL basic_max got=%0d want=4", bus.o_max); end
    total++; if (bus.o_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", bus.o_done); end
    total++; if (ce_total - run_base !== 2) begin bad++; $display("FAIL basic_reads got=%0d want=2", ce_total - run_base); end
    @(negedge clk);
    total++; if ({bus.o_valid, bus.o_done, bus.o_idle} !== 3'b001) begin
      bad++; $display("FAIL basic_after got=%b want=001", {bus.o_valid, bus.o_done, bus.o_idle}); end
    total++; if (bus.o_sum !== 48'd10) begin bad++; $display("FAIL basic_sum_kept got=%0d want=10", bus.o_sum); end
  endtask

  task automatic test_zero;
    int lat;
    run_job(0, 0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
    total++; if (bus.o_sum !== '0 || bus.o_max !== '0) begin
      bad++; $display("FAIL zero_result sum=%0d max=%0d want 0 0", bus.o_sum, bus.o_max); end
    total++; if (ce_total - run_base !== 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", ce_total - run_base); end
    @(negedge clk);
  endtask

  task automatic test_full_depth;
    int lat, err0;
    for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = 32'hFFFF_FFFF;
    err0 = addr_err;
    run_job(4096, 0, lat);
    total++; if (lat !== 4098) begin bad++; $display("FAIL full_latency got=%0d want=4098", lat); end
    total++; if (bus.o_sum !== 48'd536862720) begin bad++; $display("FAIL full_sum got=%0d want=536862720", bus.o_sum); end
    total++; if (bus.o_max !== 16'hFFFF) begin bad++; $display("FAIL full_max got=%0h want=ffff", bus.o_max); end
    total++; if (ce_total - run_base !== 4096 || addr_err !== err0) begin
      bad++; $display("FAIL full_addr reads=%0d addr_errs=%0d want 4096 0", ce_total - run_base, addr_err - err0); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    logic [ACC_WIDTH-1:0] held;
    mem[0] = 32'h0002_0001; mem[1] = 32'h0004_0003;
    bus.i_ready = 1'b0;
    run_job(2, 0, lat);
    held = bus.o_sum;
    total++; if (lat !== 4 || held !== 48'd10) begin bad++; $display("FAIL bp_first lat=%0d sum=%0d want 4 10", lat, held); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (bus.o_valid !== 1'b1 || bus.o_done !== 1'b0 || bus.o_sum !== 48'd10 || bus.o_max !== 16'd4) begin
        bad++; $display("FAIL bp_hold cyc=%0d valid=%b done=%b sum=%0d max=%0d", c, bus.o_valid, bus.o_done, bus.o_sum, bus.o_max); end
    end
    bus.i_ready = 1'b1;
    #1;
    total++; if (bus.o_done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", bus.o_done); end
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) begin
      bad++; $display("FAIL bp_release valid=%b done=%b want 0 0", bus.o_valid, bus.o_done); end
  endtask

  task automatic test_rerun_ignored;
    int lat, err0;
    mem[0] = 32'h0010_0005; mem[1] = 32'h0100_0007; mem[2] = 32'h0003_0020;
    for (int i = 3; i < 8; i++) mem[i] = 32'h0001_0001;
    err0 = addr_err;
    run_job(3, 1, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL rerun_latency got=%0d want=5", lat); end
    total++; if (bus.o_sum !== 48'd319 || bus.o_max !== 16'd256) begin
      bad++; $display("FAIL rerun_result sum=%0d max=%0d want 319 256", bus.o_sum, bus.o_max); end
    total++; if (ce_total - run_base !== 3 || addr_err !== err0) begin
      bad++; $display("FAIL rerun_reads got=%0d addr_errs=%0d want 3 0", ce_total - run_base, addr_err - err0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat;
    bus.i_run = 1'b1; bus.i_num_cnt = CNT_BIT'(3);
    @(negedge clk); bus.i_run = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (bus.o_idle !== 1'b1 || bus.ce_b1 !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_sum !== '0) begin
      bad++; $display("FAIL midreset idle=%b ce=%b busy=%b sum=%0d want 1 0 0 0", bus.o_idle, bus.ce_b1, bus.o_busy, bus.o_sum); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    run_job(3, 0, lat);
    total++; if (lat !== 5 || bus.o_sum !== 48'd319 || bus.o_max !== 16'd256) begin
      bad++; $display("FAIL midreset_rerun lat=%0d sum=%0d max=%0d want 5 319 256", lat, bus.o_sum, bus.o_max); end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.i_run = 1'b0; bus.i_num_cnt = '0; bus.i_ready = 1'b0; bus.q_b1 = '0;
    for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = '0;
    #1;
    test_reset;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    test_basic;
    test_zero;
    test_full_depth;
    test_backpressure;
    test_rerun_ignored;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
